calc_bin2bcd: RTL and testbench
===============================

# calc_bin2bcd

Sequential binary-to-BCD converter sitting directly downstream of the 64-bit integer calculator: takes one 64-bit result word per transaction and produces packed decimal digits, a sign flag and a significant-digit count for the display/readout stage. Uses shift-and-add-3 (double dabble), one bit per clock, with valid/ready handshakes on both sides so the calculator wrapper and the display driver can stall independently.

## Interface
- WIDTH, 64, binary input width.
- DIGITS, 20, BCD output digits; must be ≥ ceil(WIDTH·log10 2), which is 20 for 64.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream has a result word.
- in_ready  out  1  converter can accept; high only in IDLE.
- in_data  in  WIDTH  calculator result.
- in_signed  in  1  interpret in_data as two's complement.
- out_valid  out  1  conversion result available.
- out_ready  in  1  downstream consumes the result.
- out_bcd  out  4·DIGITS  packed BCD; digit 0 (units) in [3:0].
- out_neg  out  1  result is negative.
- out_ndigits  out  5  count of significant digits, 1..DIGITS.

## Operation
- States: IDLE, SHIFT, FINISH, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready edge: latch magnitude (if in_signed && in_data[WIDTH-1], mag = two's-complement negation, neg=1; else mag = in_data, neg=0), clear BCD accumulator, bit counter = 0, go to SHIFT.
- SHIFT: each cycle, every digit ≥5 gets +3, then {bcd, mag} shifts left by 1. Counter increments; after WIDTH shifts go to FINISH.
- FINISH: compute out_ndigits = index of highest nonzero digit + 1 (1 if value is 0); register out_bcd, out_neg, out_ndigits; out_valid=1; go to DONE.
- DONE: hold all outputs stable while out_valid && !out_ready. On out_valid&&out_ready edge: out_valid=0, go to IDLE. out_bcd/out_neg/out_ndigits keep last values until the next FINISH.
- Magnitude arithmetic is WIDTH-bit unsigned: most-negative input 0x8000_0000_0000_0000 negates to itself and reads as 2^63 — correct, no overflow.
- in_signed=0 with bit 63 set: treated as unsigned, out_neg=0.
- in_valid while not in IDLE: ignored; upstream holds data (in_ready low).
- Reset mid-conversion: aborts, no out_valid pulse, partial result discarded.

## Timing
- Reset values after rst edge: state IDLE, in_ready=1, out_valid=0, out_bcd=0, out_neg=0, out_ndigits=0.
- Latency: accept edge E0; shift edges E1..E64; FINISH edge E65; out_valid high in the cycle after E65 (WIDTH+1 cycles after acceptance).
- in_ready is low from the cycle after E0 until the cycle after the output handshake edge.
- Minimum period with out_ready held high: WIDTH+3 cycles per word (67 at WIDTH=64).
- No combinational path from in_valid/out_ready to any output; in_ready and out_valid decode from registered state.

## Structure
- Shared package calc_pkg: WIDTH=64, DIGITS=20, state enum, and the calculator opcode constants (add, sub, mul, div, mod) for the upstream wrapper.
- One sub-module: calc_bcd_add3 — 4-bit combinational digit adjust (in ≥5 → in+3), instantiated DIGITS times via generate.
- Top level holds the FSM, counter, mag/bcd shift registers and output registers.

## Test plan
- in_data=0, in_signed=0 → out_bcd=0, out_ndigits=1, out_neg=0.
- in_data=0xFFFF_FFFF_FFFF_FFFF, in_signed=0 → out_bcd digits 18446744073709551615, out_ndigits=20, out_neg=0.
- in_data=0xFFFF_FFFF_FFFF_FFFF, in_signed=1 → out_bcd=1, out_neg=1, out_ndigits=1; in_data=0x8000_0000_0000_0000, in_signed=1 → 9223372036854775808, out_neg=1, out_ndigits=19.
- in_data=12345 accepted at edge E0 → out_valid first high in cycle after E65; out_bcd=0x12345, out_ndigits=5; in_ready low throughout.
- Hold out_ready low 10 cycles in DONE → out_valid and all outputs stable, in_ready=0, second in_valid ignored; raise out_ready → in_ready high next cycle, then second word converts.
- Assert rst at shift cycle 30 → out_valid never rises, in_ready=1 and out_* =0 in cycle after reset edge; next conversion correct.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared widths, converter FSM states and upstream calculator opcodes
package calc_pkg;
  localparam int WIDTH = 64;
  localparam int DIGITS = 20;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int NDW = 5;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH, S_DONE} state_t;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD} op_t;
endpackage

// File: rtl/calc_bin2bcd_if.sv
// calc_bin2bcd_if: in_* word handshake upstream, out_* result handshake downstream; master=driver, slave=converter
interface calc_bin2bcd_if;
  import calc_pkg::*;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      in_data;
  logic                  in_signed;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_bcd;
  logic                  out_neg;
  logic [NDW-1:0]        out_ndigits;
  modport master (output in_valid, in_data, in_signed, out_ready,
                  input in_ready, out_valid, out_bcd, out_neg, out_ndigits);
  modport slave (input in_valid, in_data, in_signed, out_ready,
                 output in_ready, out_valid, out_bcd, out_neg, out_ndigits);
endinterface

// File: rtl/calc_bcd_add3.sv
// calc_bcd_add3: i_d (4b digit) -> o_d, adds 3 when digit >= 5
module calc_bcd_add3 (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);
  assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;
endmodule

// File: rtl/calc_bin2bcd.sv
// calc_bin2bcd: clk, rst, bus(slave) -- double-dabble binary to packed BCD with sign and digit count
module calc_bin2bcd
  import calc_pkg::*;
(
  input logic clk,
  input logic rst,
  calc_bin2bcd_if.slave bus
);
  state_t              r_state, w_next;
  logic [CW-1:0]       r_cnt;
  logic [WIDTH-1:0]    r_mag;
  logic [4*DIGITS-1:0] r_bcd, w_adj, r_out_bcd;
  logic                r_neg, r_out_neg, w_neg_in;
  logic [NDW-1:0]      r_out_nd, w_nd;
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    calc_bcd_add3 u_add3 (.i_d(r_bcd[4*g +: 4]), .o_d(w_adj[4*g +: 4]));
  end
  assign w_neg_in = bus.in_signed & bus.in_data[WIDTH-1];
  always_comb begin
    w_nd = NDW'(1);
    for (int k = 0; k < DIGITS; k++)
      if (r_bcd[4*k +: 4] != 4'd0) w_nd = NDW'(k + 1);
  end
  always_comb begin
    w_next = r_state;
    if (r_state == S_IDLE && bus.in_valid) w_next = S_SHIFT;
    if (r_state == S_SHIFT && r_cnt == CW'(WIDTH - 1)) w_next = S_FINISH;
    if (r_state == S_FINISH) w_next = S_DONE;
    if (r_state == S_DONE && bus.out_ready) w_next = S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_mag     <= '0;
      r_bcd     <= '0;
      r_neg     <= 1'b0;
      r_out_bcd <= '0;
      r_out_neg <= 1'b0;
      r_out_nd  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && bus.in_valid) begin
        r_mag <= w_neg_in ? -bus.in_data : bus.in_data;
        r_neg <= w_neg_in;
        r_bcd <= '0;
        r_cnt <= '0;
      end
      if (r_state == S_SHIFT) begin
        r_bcd <= {w_adj[4*DIGITS-2:0], r_mag[WIDTH-1]};
        r_mag <= {r_mag[WIDTH-2:0], 1'b0};
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == S_FINISH) begin
        r_out_bcd <= r_bcd;
        r_out_neg <= r_neg;
        r_out_nd  <= w_nd;
      end
    end
  end
  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.out_valid   = (r_state == S_DONE);
  assign bus.out_bcd     = r_out_bcd;
  assign bus.out_neg     = r_out_neg;
  assign bus.out_ndigits = r_out_nd;
endmodule

// File: tb/tb_calc_bin2bcd.sv
// tb_calc_bin2bcd: vector table, handshake corner sequences and random words against a decimal model
module tb_calc_bin2bcd;
  import calc_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  calc_bin2bcd_if bus ();
  calc_bin2bcd dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [63:0] d;
    logic        s;
    logic [79:0] bcd;
    logic        neg;
    logic [4:0]  nd;
  } vec_t;
  vec_t vt[8];
  task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  task automatic model(input logic [63:0] d, input logic s, output logic [79:0] b, output logic n, output logic [4:0] nd);
    logic [63:0] m;
    logic [63:0] dig;
    n = s && d[63];
    m = n ? (~d + 64'd1) : d;
    b = '0;
    nd = 5'd1;
    for (int k = 0; k < 20; k++) begin
      dig = m % 64'd10;
      m = m / 64'd10;
      b[4*k +: 4] = dig[3:0];
      if (dig != 0) nd = 5'(k + 1);
    end
  endtask
  task automatic wait_valid(output int lat, output logic rdy_seen);
    lat = 0;
    rdy_seen = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic start(input logic [63:0] d, input logic s);
    @(negedge clk);
    bus.in_data = d;
    bus.in_signed = s;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask
  task automatic xfer(input string nm, input logic [63:0] d, input logic s);
    logic [79:0] eb;
    logic en;
    logic [4:0] end_;
    int lat;
    logic rs;
    model(d, s, eb, en, end_);
    start(d, s);
    wait_valid(lat, rs);
    chk({nm, "_lat"}, 80'(lat), 80'(WIDTH + 1));
    chk({nm, "_rdy_low"}, 80'(rs), 80'd0);
    chk({nm, "_bcd"}, bus.out_bcd, eb);
    chk({nm, "_neg"}, 80'(bus.out_neg), 80'(en));
    chk({nm, "_nd"}, 80'(bus.out_ndigits), 80'(end_));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask
  initial begin
    logic [79:0] eb, cb;
    logic en, cn, seen, rs;
    logic [4:0] end_, cnd;
    int lat;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b0;
    vt[0] = '{64'd0, 1'b0, 80'h0, 1'b0, 5'd1};
    vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 80'h18446744073709551615, 1'b0, 5'd20};
    vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 80'h1, 1'b1, 5'd1};
    vt[3] = '{64'h8000_0000_0000_0000, 1'b1, 80'h9223372036854775808, 1'b1, 5'd19};
    vt[4] = '{64'd12345, 1'b0, 80'h12345, 1'b0, 5'd5};
    vt[5] = '{64'h8000_0000_0000_0000, 1'b0, 80'h9223372036854775808, 1'b0, 5'd19};
    vt[6] = '{64'd10, 1'b1, 80'h10, 1'b0, 5'd2};
    vt[7] = '{64'hFFFF_FFFF_FFFF_FF9D, 1'b1, 80'h99, 1'b1, 5'd2};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 80'(bus.in_ready), 80'd1);
    chk("rst_out_valid", 80'(bus.out_valid), 80'd0);
    chk("rst_bcd", bus.out_bcd, 80'd0);
    chk("rst_neg", 80'(bus.out_neg), 80'd0);
    chk("rst_nd", 80'(bus.out_ndigits), 80'd0);
    foreach (vt[i]) begin
      start(vt[i].d, vt[i].s);
      wait_valid(lat, rs);
      chk($sformatf("vec%0d_lat", i), 80'(lat), 80'(WIDTH + 1));
      chk($sformatf("vec%0d_rdy_low", i), 80'(rs), 80'd0);
      chk($sformatf("vec%0d_bcd", i), bus.out_bcd, vt[i].bcd);
      chk($sformatf("vec%0d_neg", i), 80'(bus.out_neg), 80'(vt[i].neg));
      chk($sformatf("vec%0d_nd", i), 80'(bus.out_ndigits), 80'(vt[i].nd));
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk($sformatf("vec%0d_back_idle", i), 80'({bus.in_ready, bus.out_valid}), 80'b10);
    end
    start(64'd987654321, 1'b0);
    wait_valid(lat, rs);
    model(64'd987654321, 1'b0, eb, en, end_);
    chk("stall_bcd", bus.out_bcd, eb);
    cb = bus.out_bcd;
    cn = bus.out_neg;
    cnd = bus.out_ndigits;
    bus.in_data = 64'hFFFF_FFFF_FFFF_FC18;
    bus.in_signed = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", 80'(bus.out_valid), 80'd1);
      chk("stall_in_ready", 80'(bus.in_ready), 80'd0);
      chk("stall_hold", {bus.out_bcd[74:0], bus.out_neg, bus.out_ndigits[3:0]}, {cb[74:0], cn, cnd[3:0]});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("stall_release", 80'({bus.in_ready, bus.out_valid}), 80'b10);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_valid(lat, rs);
    model(64'hFFFF_FFFF_FFFF_FC18, 1'b1, eb, en, end_);
    chk("second_lat", 80'(lat), 80'(WIDTH + 1));
    chk("second_bcd", bus.out_bcd, eb);
    chk("second_neg", 80'(bus.out_neg), 80'(en));
    chk("second_nd", 80'(bus.out_ndigits), 80'(end_));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    start(64'd55555, 1'b1);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", 80'(bus.in_ready), 80'd1);
    chk("abort_out_valid", 80'(bus.out_valid), 80'd0);
    chk("abort_out", {bus.out_bcd, bus.out_neg, bus.out_ndigits}, '0);
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", 80'(seen), 80'd0);
    xfer("after_abort", 64'd4096, 1'b0);
    for (int i = 0; i < 40; i++)
      xfer($sformatf("rnd%0d", i), {32'($urandom), 32'($urandom)} >> $urandom_range(0, 63), 1'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
